// File: rtl/dmem_lsu_if.sv
// Request/response bus between the execute stage and the data memory LSU.
// The master drives requests and the slave returns a one-cycle response pulse.
interface dmem_lsu_if #(
    parameter int AW = 11
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I byte-addressable data memory with built-in load/store unit.
// Requests are checked and executed at the accept edge; the response is
// delayed by LATENCY wait cycles and presented as a single-cycle pulse.
module dmem_lsu #(
    parameter  int DEPTH   = 2048,
    parameter  int LATENCY = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    dmem_lsu_if.slave bus
);
    localparam int         WORDS    = DEPTH / 4;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     pend_rdata_q, pend_rdata_d;
    logic            pend_err_q, pend_err_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [3:0][7:0] mem [WORDS];

    logic            accept;
    logic            acc_legal, acc_mis, acc_err;
    logic [AW-3:0]   widx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [3:0][7:0] wbytes;
    logic [3:0][7:0] rword;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [31:0]     ld_res;

    // Decode the request: legality, alignment, store lanes and extended load data.
    always_comb begin
        widx = bus.req_addr[AW-1:2];
        lane = bus.req_addr[1:0];
        if (bus.req_we)
            acc_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            acc_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (bus.req_funct3[1:0])
            2'b01:   acc_mis = lane[0];
            2'b10:   acc_mis = |lane;
            default: acc_mis = 1'b0;
        endcase
        acc_err = !acc_legal || acc_mis;
        // A request coinciding with reset is never taken.
        accept  = (state_q == S_IDLE) && bus.req_valid && !rst;

        // Store data is replicated so every enabled lane sees the right bytes.
        case (bus.req_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wbytes = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << {lane[1], 1'b0};
                wbytes = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wbytes = bus.req_wdata;
            end
        endcase

        rword = mem[widx];
        rbyte = rword[lane];
        rhalf = lane[1] ? rword[3:2] : rword[1:0];
        case (bus.req_funct3)
            3'b000:  ld_res = {{24{rbyte[7]}}, rbyte};
            3'b100:  ld_res = {24'd0, rbyte};
            3'b001:  ld_res = {{16{rhalf[15]}}, rhalf};
            3'b101:  ld_res = {16'd0, rhalf};
            3'b010:  ld_res = rword;
            default: ld_res = '0;
        endcase
        if (bus.req_we || acc_err)
            ld_res = '0;
    end

    // Byte-enabled store, committed at the accept edge; faulting stores are dropped.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !acc_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][b] <= wbytes[b];
        end
    end

    // FSM and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next state: response regs only change on entry to RESP so they hold otherwise.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d      = S_WAIT;
                        cnt_d        = CNT_INIT;
                        pend_rdata_d = ld_res;
                        pend_err_d   = acc_err;
                    end else begin
                        state_d     = S_RESP;
                        rsp_rdata_d = ld_res;
                        rsp_err_d   = acc_err;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = pend_rdata_q;
                    rsp_err_d   = pend_err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a zero-latency and a three-cycle instance share the
// same stimulus and a byte-array reference model of memory contents.
module tb_dmem_lsu;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_lsu_if #(.AW(AW)) bus0 ();
    dmem_lsu_if #(.AW(AW)) bus3 ();

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mm [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: n-byte little-endian access on a byte array.
    function automatic void model(input bit we, input logic [2:0] f3, input logic [7:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int unsigned n;
        bit          legal;
        longint      v;
        n     = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : !(f3 inside {3'd3, 3'd6, 3'd7});
        rd    = '0;
        err   = !legal || ((int'(a) % n) != 0);
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++) mm[(int'(a) + i) % DEPTH] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < int'(n); i++) v = v | (longint'(mm[(int'(a) + i) % DEPTH]) << (8*i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
            rd = v[31:0];
        end
    endfunction

    task automatic drive(input bit v, input bit we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd);
        bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3; bus0.req_addr = a; bus0.req_wdata = wd;
        bus3.req_valid = v; bus3.req_we = we; bus3.req_funct3 = f3; bus3.req_addr = a; bus3.req_wdata = wd;
    endtask

    // One request on both instances; checks latency, pulse width, ready and data.
    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] rd0, output logic e0);
        logic [31:0] erd, r3;
        bit          eerr;
        logic        e3;
        int          seen0, seen3, k0, k3;
        seen0 = 0; seen3 = 0; k0 = 0; k3 = 0; rd0 = '0; r3 = '0; e0 = 1'b0; e3 = 1'b0;
        model(we, f3, a, wd, erd, eerr);
        @(negedge clk);
        drive(1'b1, we, f3, a, wd);
        chk("rdy0_idle", 32'(bus0.req_ready), 32'd1);
        chk("rdy3_idle", 32'(bus3.req_ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus0.req_valid = 1'b0;
            if (k == 1) bus3.req_valid = 1'b0;
            if (bus0.rsp_valid) begin seen0++; k0 = k; rd0 = bus0.rsp_rdata; e0 = bus0.rsp_err; end
            if (bus3.rsp_valid) begin seen3++; k3 = k; r3 = bus3.rsp_rdata; e3 = bus3.rsp_err; end
            chk("rdy0", 32'(bus0.req_ready), 32'(k > 1));
            chk("rdy3", 32'(bus3.req_ready), 32'(k > 4));
        end
        chk("pulses0", 32'(seen0), 32'd1);
        chk("lat0", 32'(k0), 32'd1);
        chk("rdata0", rd0, erd);
        chk("err0", 32'(e0), 32'(eerr));
        chk("pulses3", 32'(seen3), 32'd1);
        chk("lat3", 32'(k3), 32'd4);
        chk("rdata3", r3, erd);
        chk("err3", 32'(e3), 32'(eerr));
    endtask

    initial begin
        logic [31:0] rd, ea, eb;
        logic        er;
        bit          eerr;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(bus0.req_ready), 32'd1);
        chk("rst_vld", 32'(bus0.rsp_valid), 32'd0);
        chk("rst_rdata", bus0.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus0.rsp_err), 32'd0);
        chk("rst_rdy3", 32'(bus3.req_ready), 32'd1);
        chk("rst_vld3", 32'(bus3.rsp_valid), 32'd0);
        rst = 1'b0;

        // Fill memory so the model is exact everywhere.
        for (int w = 0; w < DEPTH/4; w++) do_txn(1'b1, 3'b010, 8'(w*4), $urandom, rd, er);

        do_txn(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, rd, er);
        chk("sw10_rdata", rd, 32'd0);
        do_txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er);
        chk("lw10", rd, 32'hDEADBEEF);
        chk("lw10_err", 32'(er), 32'd0);

        do_txn(1'b1, 3'b010, 8'h20, 32'h80FF7F01, rd, er);
        do_txn(1'b0, 3'b000, 8'h21, 32'd0, rd, er); chk("lb21", rd, 32'h0000007F);
        do_txn(1'b0, 3'b000, 8'h22, 32'd0, rd, er); chk("lb22", rd, 32'hFFFFFFFF);
        do_txn(1'b0, 3'b100, 8'h23, 32'd0, rd, er); chk("lbu23", rd, 32'h00000080);
        do_txn(1'b0, 3'b001, 8'h22, 32'd0, rd, er); chk("lh22", rd, 32'hFFFF80FF);
        do_txn(1'b0, 3'b101, 8'h22, 32'd0, rd, er); chk("lhu22", rd, 32'h000080FF);

        do_txn(1'b1, 3'b010, 8'h30, 32'd0, rd, er);
        do_txn(1'b1, 3'b000, 8'h31, 32'h123456AB, rd, er);
        do_txn(1'b0, 3'b010, 8'h30, 32'd0, rd, er); chk("sb31", rd, 32'h0000AB00);
        do_txn(1'b1, 3'b001, 8'h32, 32'h0000CDEF, rd, er);
        do_txn(1'b0, 3'b010, 8'h30, 32'd0, rd, er); chk("sh32", rd, 32'hCDEFAB00);

        do_txn(1'b1, 3'b010, 8'h40, 32'h11223344, rd, er);
        do_txn(1'b0, 3'b010, 8'h41, 32'd0, rd, er);
        chk("lw41_err", 32'(er), 32'd1); chk("lw41_rdata", rd, 32'd0);
        do_txn(1'b1, 3'b001, 8'h43, 32'hFFFFFFFF, rd, er); chk("sh43_err", 32'(er), 32'd1);
        do_txn(1'b0, 3'b010, 8'h40, 32'd0, rd, er); chk("w40_kept", rd, 32'h11223344);
        do_txn(1'b0, 3'b011, 8'h40, 32'd0, rd, er); chk("f3_011_err", 32'(er), 32'd1);
        do_txn(1'b1, 3'b100, 8'h40, 32'h55, rd, er); chk("sf3_100_err", 32'(er), 32'd1);

        do_txn(1'b1, 3'b010, 8'(DEPTH-4), 32'hA5A55A5A, rd, er);
        do_txn(1'b0, 3'b010, 8'(DEPTH-4), 32'd0, rd, er); chk("wrap_top", rd, 32'hA5A55A5A);

        // Slow instance under a held request: second one waits for IDLE.
        model(1'b0, 3'b010, 8'h10, 32'd0, ea, eerr);
        model(1'b0, 3'b010, 8'h20, 32'd0, eb, eerr);
        @(negedge clk);
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_funct3 = 3'b010;
        bus3.req_addr = 8'h10;  bus3.req_wdata = 32'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus3.req_addr = 8'h20;
            if (k == 6) bus3.req_valid = 1'b0;
            chk("bp_rdy", 32'(bus3.req_ready), 32'(k == 5 || k == 10));
            chk("bp_vld", 32'(bus3.rsp_valid), 32'(k == 4 || k == 9));
            chk("bp_idle0", 32'(bus0.rsp_valid), 32'd0);
            if (k == 4) chk("bp_rdA", bus3.rsp_rdata, ea);
            if (k == 9) chk("bp_rdB", bus3.rsp_rdata, eb);
            if (k == 7) chk("bp_hold", bus3.rsp_rdata, ea);
        end

        // Reset while the slow instance waits: the response is dropped.
        @(negedge clk);
        bus3.req_valid = 1'b1; bus3.req_addr = 8'h10;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus3.req_valid = 1'b0;
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                chk("rstw_rdy", 32'(bus3.req_ready), 32'd1);
            end
            if (k >= 3) chk("rstw_novld", 32'(bus3.rsp_valid), 32'd0);
        end

        // Store accepted just before reset stays committed.
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 8'h50, 32'hCAFEF00D);
        model(1'b1, 3'b010, 8'h50, 32'hCAFEF00D, rd, eerr);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b010, 8'h50, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b0, 3'b010, 8'h50, 32'd0, rd, er); chk("st_pre_rst", rd, 32'hCAFEF00D);

        // Request during reset is ignored.
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 8'h60, 32'h0BADC0DE);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b010, 8'h60, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rstreq_novld0", 32'(bus0.rsp_valid), 32'd0);
            chk("rstreq_novld3", 32'(bus3.rsp_valid), 32'd0);
        end
        do_txn(1'b0, 3'b010, 8'h60, 32'd0, rd, er);
        chk("rstreq_nowr", 32'(rd == 32'h0BADC0DE), 32'd0);

        // Random mix, mostly legal and aligned.
        for (int t = 0; t < 150; t++) begin
            bit          we;
            logic [2:0]  f3;
            logic [7:0]  a;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else    f3 = 3'($urandom_range(0, 4)) + ($urandom_range(0, 4) > 2 ? 3'd0 : 3'd0);
                if (!we && f3 == 3'd3) f3 = 3'd5;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = 8'($urandom_range(0, DEPTH-1));
            if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << f3[1:0]) - 1);
            do_txn(we, f3, a, $urandom, rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
